// File: rtl/ex_elastic_reg.sv
// EX/MEM elastic buffer: DEPTH-entry circular queue with valid/ready handshakes on both sides.
// Optional performance counters are enabled by defining EX_ELASTIC_PERF_CNT_EN.
module ex_elastic_reg #(
    parameter int                 PC_W         = 30,
    parameter int                 DATA_W       = 32,
    parameter int                 REGA_W       = 5,
    parameter int                 MEMOP_W      = 2,
    parameter int                 CTRLOP_W     = 2,
    parameter int                 EXP_W        = 3,
    parameter logic [EXP_W-1:0]   EXP_OVF_CODE = EXP_W'(4),
    parameter int                 DEPTH        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          int_detect,
    input  logic [DATA_W-1:0]             alu_out,
    input  logic                          alu_of,
    input  logic                          id_valid,
    output logic                          id_ready,
    input  logic [PC_W-1:0]               id_pc,
    input  logic                          id_br_flag,
    input  logic [MEMOP_W-1:0]            id_mem_op,
    input  logic [DATA_W-1:0]             id_mem_wr_data,
    input  logic [CTRLOP_W-1:0]           id_ctrl_op,
    input  logic [REGA_W-1:0]             id_dst_addr,
    input  logic                          id_gpr_we_,
    input  logic [EXP_W-1:0]              id_exp_code,
    input  logic                          mem_ready,
    output logic                          ex_valid,
    output logic [PC_W-1:0]               ex_pc,
    output logic                          ex_br_flag,
    output logic [MEMOP_W-1:0]            ex_mem_op,
    output logic [DATA_W-1:0]             ex_mem_wr_data,
    output logic [CTRLOP_W-1:0]           ex_ctrl_op,
    output logic [REGA_W-1:0]             ex_dst_addr,
    output logic                          ex_gpr_we_,
    output logic [EXP_W-1:0]              ex_exp_code,
    output logic [DATA_W-1:0]             ex_out,
    output logic [$clog2(DEPTH+1)-1:0]    ex_count
`ifdef EX_ELASTIC_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_bp_cnt,
    output logic [31:0]                   perf_kill_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
        $error("ex_elastic_reg: DEPTH must be in 2..8");
    end

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic                br_flag;
        logic [MEMOP_W-1:0]  mem_op;
        logic [DATA_W-1:0]   mem_wr_data;
        logic [CTRLOP_W-1:0] ctrl_op;
        logic [REGA_W-1:0]   dst_addr;
        logic                gpr_we_;
        logic [EXP_W-1:0]    exp_code;
        logic [DATA_W-1:0]   out;
    } entry_t;

    entry_t             store_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    entry_t             new_entry;
    entry_t             head;
    logic               kill;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign kill     = flush | int_detect;
    assign id_ready = (count < CNT_W'(DEPTH));
    assign ex_valid = (count != '0);
    assign push     = id_valid & id_ready & ~stall & ~kill;
    assign pop      = ex_valid & mem_ready & ~stall & ~kill;
    assign ex_count = count;

    // An upstream exception wins over overflow; overflow squashes side effects.
    always_comb begin
        new_entry.pc          = id_pc;
        new_entry.br_flag     = id_br_flag;
        new_entry.mem_op      = id_mem_op;
        new_entry.mem_wr_data = id_mem_wr_data;
        new_entry.ctrl_op     = id_ctrl_op;
        new_entry.dst_addr    = id_dst_addr;
        new_entry.gpr_we_     = id_gpr_we_;
        new_entry.exp_code    = id_exp_code;
        new_entry.out         = alu_out;
        if (alu_of && id_exp_code == '0) begin
            new_entry.exp_code = EXP_OVF_CODE;
            new_entry.mem_op   = '0;
            new_entry.ctrl_op  = '0;
            new_entry.gpr_we_  = 1'b1;
        end
    end

    always_comb begin
        head         = '0;
        head.gpr_we_ = 1'b1;
        if (ex_valid) begin
            head = store_q[rd_ptr];
        end
    end

    assign ex_pc          = head.pc;
    assign ex_br_flag     = head.br_flag;
    assign ex_mem_op      = head.mem_op;
    assign ex_mem_wr_data = head.mem_wr_data;
    assign ex_ctrl_op     = head.ctrl_op;
    assign ex_dst_addr    = head.dst_addr;
    assign ex_gpr_we_     = head.gpr_we_;
    assign ex_exp_code    = head.exp_code;
    assign ex_out         = head.out;

    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef EX_ELASTIC_PERF_CNT_EN
    logic        bp_inc;
    logic [32:0] kill_sum;

    assign bp_inc   = ex_valid & (~mem_ready | stall);
    assign kill_sum = {1'b0, perf_kill_cnt} + 33'(count);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_bp_cnt   <= '0;
            perf_kill_cnt <= '0;
        end else begin
            if (bp_inc && perf_bp_cnt != '1) begin
                perf_bp_cnt <= perf_bp_cnt + 1'b1;
            end
            if (kill) begin
                perf_kill_cnt <= kill_sum[32] ? '1 : kill_sum[31:0];
            end
        end
    end
`endif

endmodule
